// File: rtl/mux_n_to_1_reg.sv
// N-to-1 registered multiplexer with per-channel valid/ready handshake and a one-word output register.
// Define MUX_RR_ARB_EN to replace the fixed i_sel select with round-robin arbitration.
module mux_n_to_1_reg #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_valid,
    output logic [NUM_CH-1:0]        o_ready,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [SEL_W-1:0]         o_ch
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic [SEL_W-1:0]    ch_q;
    logic [SEL_W-1:0]    ch_d;
    logic                sel_vld;
    logic                load_en;
    logic                xfer;
    logic [DATA_W-1:0]   ch_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_data[g] = i_data[g*DATA_W +: DATA_W];
    end

    assign load_en = (state_q == EMPTY) | i_ready;

`ifdef MUX_RR_ARB_EN
    logic [SEL_W-1:0] last_q;
    logic             unused_sel;

    assign unused_sel = ^i_sel;

    // Scan from the farthest candidate down to last+1 so the nearest valid channel wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx     = '0;
        ch_d    = '0;
        sel_vld = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = SEL_W'((int'(last_q) + i) % NUM_CH);
            if (i_valid[idx]) begin
                ch_d    = idx;
                sel_vld = 1'b1;
            end
        end
    end
`else
    always_comb begin
        ch_d    = i_sel;
        sel_vld = (int'(i_sel) < NUM_CH);
    end
`endif

    // Compare-based mux keeps the output defined for out-of-range select values.
    always_comb begin
        data_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_d == SEL_W'(k)) begin
                data_d = ch_data[k];
            end
        end
    end

    always_comb begin
        o_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            o_ready[k] = i_rst_n & load_en & sel_vld & (ch_d == SEL_W'(k));
        end
    end

    assign xfer = |(o_ready & i_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
`ifdef MUX_RR_ARB_EN
            last_q  <= SEL_W'(NUM_CH - 1);
`endif
        end else begin
            if (xfer) begin
                state_q <= FULL;
                data_q  <= data_d;
                ch_q    <= ch_d;
`ifdef MUX_RR_ARB_EN
                last_q  <= ch_d;
`endif
            end else if (i_ready) begin
                state_q <= EMPTY;
            end
        end
    end

    assign o_valid = (state_q == FULL);
    assign o_data  = data_q;
    assign o_ch    = ch_q;

endmodule
